pipeline_hazard_ctrl: RTL

- Central stall/flush/forwarding controller for the 5-stage pipeline.
- Drives the EN (hold, 1 = keep value) and CLR (bubble) inputs of the F, D, E, M and W pipeline registers.
- Generates the ALU operand forwarding selects.
- Sequences a fixed-latency multiply/divide unit sitting in Execute, and freezes the pipe on data-memory wait.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/md_seq.sv | 76 +++++++
 rtl/pipeline_hazard_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller and its
// multiply/divide sequencer.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } md_state_t;

    // Saturating increment used by the optional performance counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
        return (en && (value != 32'hFFFF_FFFF)) ? value + 32'd1 : value;
    endfunction

endpackage

// File: rtl/md_seq.sv
// Fixed-latency multiply/divide sequencer: IDLE -> RUN (MD_LATENCY cycles) -> DONE.
// Produces the start pulse, capture strobe, busy flag and the mul/div stall term.
module md_seq
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = $clog2(MD_LATENCY + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic muldiv,
    input  logic mw,
    output logic mdst,
    output logic md_start,
    output logic md_capture,
    output logic md_busy
);

    md_state_t        state;
    md_state_t        state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            md_busy <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            md_busy <= (state_next != IDLE);
        end
    end

    // NOTE: every variable gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            IDLE: begin
                if (muldiv && !mw) begin
                    state_next = RUN;
                    cnt_next   = CNT_W'(MD_LATENCY - 1);
                end
            end
            RUN: begin
                // The unit keeps computing through a memory wait.
                if (cnt == '0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                // Never restarts from here: E still holds the finished op.
                if (!mw) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        md_start   = rst && (state == IDLE) && muldiv && !mw;
        md_capture = (state == DONE);
        mdst       = ((state == IDLE) && muldiv) || (state == RUN);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush/mul-div counters.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = $clog2(MD_LATENCY + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] Rs1E,
    input  logic [REG_ADDR_W-1:0] Rs2E,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic                  LoadE,
    input  logic                  PCSrcE,
    input  logic                  MulDivE,
    input  logic                  DMemReqM,
    input  logic                  DMemReadyM,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  StallM,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushM,
    output logic                  FlushW,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  md_start,
    output logic                  md_capture,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]           perf_stall_cycles,
    output logic [31:0]           perf_flush_cnt,
    output logic [31:0]           perf_md_ops,
`endif
    output logic                  md_busy
);

    logic lw;
    logic mw;
    logic mdst;

    md_seq #(
        .MD_LATENCY (MD_LATENCY),
        .CNT_W      (CNT_W)
    ) u_md_seq (
        .clk        (clk),
        .rst        (rst),
        .muldiv     (MulDivE),
        .mw         (mw),
        .mdst       (mdst),
        .md_start   (md_start),
        .md_capture (md_capture),
        .md_busy    (md_busy)
    );

    // Memory stage result takes priority: it is the younger producer.
    always_comb begin
        ForwardAE = FWD_RF;
        if (RegWriteM && (RdM != '0) && (RdM == Rs1E)) begin
            ForwardAE = FWD_MEM;
        end else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) begin
            ForwardAE = FWD_WB;
        end

        ForwardBE = FWD_RF;
        if (RegWriteM && (RdM != '0) && (RdM == Rs2E)) begin
            ForwardBE = FWD_MEM;
        end else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) begin
            ForwardBE = FWD_WB;
        end
    end

    always_comb begin
        lw = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
        mw = DMemReqM && !DMemReadyM;

        StallM = mw;
        StallE = mw || mdst;
        StallF = mw || mdst || lw;
        StallD = mw || mdst || lw;

        // A held register is never cleared; a deferred branch fires once E moves.
        FlushW = mw;
        FlushM = mdst && !mw;
        FlushE = (lw || PCSrcE) && !StallE;
        FlushD = PCSrcE && !StallD;
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cycles <= '0;
            perf_flush_cnt    <= '0;
            perf_md_ops       <= '0;
        end else begin
            perf_stall_cycles <= sat_inc(perf_stall_cycles, StallF);
            perf_flush_cnt    <= sat_inc(perf_flush_cnt, FlushE);
            perf_md_ops       <= sat_inc(perf_md_ops, md_start);
        end
    end
`endif

endmodule
